db15_joy_scan: RTL and testbench

DB15_JOY_SCAN -- requirements
Module: db15_joy_scan

---
 rtl/db15_joy_scan_if.sv | 36 +++
 rtl/db15_joy_scan.sv | 167 ++++++++++++++++
 tb/tb_db15_joy_scan.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/db15_joy_scan_if.sv
// ============================================================================
// Module      : db15_joy_scan_if
// Description : DB15 joystick adapter pins plus decoded button outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface db15_joy_scan_if;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  // master = the scanner, slave = the adapter/shift-register side and consumers
  modport master (
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output joystick1,
    output joystick2,
    output frame_done
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  joystick1,
    input  joystick2,
    input  frame_done
  );
endinterface

`default_nettype wire

// File: rtl/db15_joy_scan.sv
// ============================================================================
// Module      : db15_joy_scan
// Description : Scans a 24-bit DB15 joystick shift register and publishes
//               two active-high 12-button words once per frame.
//               Optional macro DB15_DEBOUNCE_EN: publish only when two
//               consecutive frames carry identical bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module db15_joy_scan #(
  parameter int CLK_DIV   = 48,
  parameter int GAP_TICKS = 16
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  db15_joy_scan_if.master joy
);

  localparam int              PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   c_PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]      c_GAP_LAST  = 8'(GAP_TICKS - 1);
  localparam logic [7:0]      c_LOAD_LAST = 8'd1;
  localparam logic [4:0]      c_LAST_BIT  = 5'd23;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_LOAD     = 3'd1;
  localparam logic [2:0] c_SHIFT_LO = 3'd2;
  localparam logic [2:0] c_SHIFT_HI = 3'd3;
  localparam logic [2:0] c_GAP      = 3'd4;

  logic [PW-1:0] presc_q, presc_d;
  logic          w_tick;
  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [23:0]   bits_q, bits_d;
  logic          sync1_q, sync2_q;
  logic          clk_q, clk_d;
  logic          load_q, load_d;
  logic [15:0]   joy1_q, joy2_q;
  logic          done_q;
  logic          w_frame_end;
  logic          w_publish;

  assign w_tick  = (presc_q == c_PRESC_MAX);
  assign presc_d = w_tick ? '0 : presc_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    bits_d      = bits_q;
    clk_d       = clk_q;
    load_d      = load_q;
    w_frame_end = 1'b0;
    if (w_tick) begin
      case (state_q)
        c_IDLE: begin
          state_d = c_LOAD;
          cnt_d   = '0;
          load_d  = 1'b0;
          clk_d   = 1'b1;
        end
        c_LOAD: begin
          if (cnt_q == c_LOAD_LAST) begin
            // LOAD released on the same edge JOY_CLK falls: never both low
            state_d = c_SHIFT_LO;
            idx_d   = '0;
            load_d  = 1'b1;
            clk_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        c_SHIFT_LO: begin
          bits_d[idx_q] = sync2_q;
          state_d       = c_SHIFT_HI;
          clk_d         = 1'b1;
        end
        c_SHIFT_HI: begin
          if (idx_q == c_LAST_BIT) begin
            state_d     = c_GAP;
            cnt_d       = '0;
            w_frame_end = 1'b1;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = c_SHIFT_LO;
            clk_d   = 1'b0;
          end
        end
        c_GAP: begin
          if (cnt_q == c_GAP_LAST) begin
            state_d = c_LOAD;
            cnt_d   = '0;
            load_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = c_IDLE;
          load_d  = 1'b1;
          clk_d   = 1'b1;
        end
      endcase
    end
  end

`ifdef DB15_DEBOUNCE_EN
  logic [23:0] ref_q;

  assign w_publish = w_frame_end && (bits_q == ref_q);

  // Reference starts as the released (all-ones) line so an idle first frame publishes
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ref_q <= '1;
    end else if (w_frame_end) begin
      ref_q <= bits_q;
    end
  end
`else
  assign w_publish = w_frame_end;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      state_q <= c_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clk_q   <= 1'b1;
      load_q  <= 1'b1;
      joy1_q  <= '0;
      joy2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
      sync1_q <= joy.JOY_DATA;
      sync2_q <= sync1_q;
      clk_q   <= clk_d;
      load_q  <= load_d;
      done_q  <= w_publish;
      if (w_publish) begin
        joy1_q <= {4'b0000, ~bits_q[11:0]};
        joy2_q <= {4'b0000, ~bits_q[23:12]};
      end
    end
  end

  assign joy.JOY_CLK    = clk_q;
  assign joy.JOY_LOAD   = load_q;
  assign joy.joystick1  = joy1_q;
  assign joy.joystick2  = joy2_q;
  assign joy.frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_db15_joy_scan.sv
// ============================================================================
// Module      : tb_db15_joy_scan
// Description : Self-checking bench for db15_joy_scan with an external
//               shift-register emulation and a tick-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_db15_joy_scan;

  localparam int CLK_DIV   = 48;
  localparam int GAP_TICKS = 16;
  localparam int FRAME_TK  = 2 + 48 + GAP_TICKS;
  localparam int FRAME_CYC = FRAME_TK * CLK_DIV;
  localparam int WAIT_LIM  = 3 * FRAME_CYC + 200;
`ifdef DB15_DEBOUNCE_EN
  localparam bit DEBOUNCE = 1'b1;
`else
  localparam bit DEBOUNCE = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  db15_joy_scan_if joy_if ();

  db15_joy_scan #(
    .CLK_DIV   (CLK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .joy     (joy_if.master)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;
  int done_cnt = 0;
  int err_load = 0, err_clk = 0, err_done = 0, err_joy = 0, err_inv = 0;
  logic [23:0] pattern = '1;
  logic [23:0] latched = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // cycles since reset release, counted on the active edge
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) n = 0;
    else          n = n + 1;
  end

  // External 24-bit parallel-in/serial-out register
  initial begin : emul
    logic [23:0] sr;
    logic        prev_clk;
    sr = '1;
    prev_clk = 1'b1;
    joy_if.JOY_DATA = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (joy_if.JOY_LOAD === 1'b0) begin
        sr      = pattern;
        latched = pattern;
      end else if (joy_if.JOY_CLK === 1'b1 && prev_clk === 1'b0) begin
        sr = {1'b1, sr[23:1]};
      end
      prev_clk = joy_if.JOY_CLK;
      joy_if.JOY_DATA = sr[0];
    end
  end

  // Reference timeline: tick k happens at cycle k*CLK_DIV; frame positions are tick offsets
  initial begin : model
    int k, q;
    logic exp_load, exp_clk, exp_done, pub;
    logic [23:0] ref_m;
    logic [15:0] m_j1, m_j2;
    ref_m = '1; m_j1 = '0; m_j2 = '0;
    forever begin
      @(negedge clk_sys);
      exp_load = 1'b1; exp_clk = 1'b1; exp_done = 1'b0;
      if (reset_n !== 1'b1) begin
        ref_m = '1; m_j1 = '0; m_j2 = '0;
      end else begin
        k = n / CLK_DIV;
        if (k >= 1) begin
          q = (k - 1) % FRAME_TK;
          if (q < 2)       exp_load = 1'b0;
          else if (q < 50) exp_clk  = ((q - 2) % 2 == 1);
          if (q == 50 && (n % CLK_DIV) == 0) begin
            pub = DEBOUNCE ? (latched == ref_m) : 1'b1;
            ref_m = latched;
            if (pub) begin
              m_j1 = {4'b0000, ~latched[11:0]};
              m_j2 = {4'b0000, ~latched[23:12]};
            end
            exp_done = pub;
          end
        end
      end
      if (joy_if.frame_done === 1'b1) done_cnt++;
      if (joy_if.JOY_LOAD !== exp_load) err_load++;
      if (joy_if.JOY_CLK !== exp_clk) err_clk++;
      if (joy_if.frame_done !== exp_done) err_done++;
      if (joy_if.joystick1 !== m_j1 || joy_if.joystick2 !== m_j2) err_joy++;
      if ((joy_if.JOY_LOAD === 1'b0 && joy_if.JOY_CLK === 1'b0) ||
          joy_if.joystick1[15:12] !== 4'h0 || joy_if.joystick2[15:12] !== 4'h0) err_inv++;
    end
  end

  task automatic wait_load(input string name, input logic lvl);
    int c = 0;
    while (joy_if.JOY_LOAD !== lvl && c < WAIT_LIM) begin
      @(negedge clk_sys);
      c++;
    end
    chk({"timeout ", name}, 32'(c >= WAIT_LIM), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    do begin
      @(negedge clk_sys);
      c++;
    end while (joy_if.frame_done !== 1'b1 && c < WAIT_LIM);
    chk({"timeout ", name}, 32'(c >= WAIT_LIM), 32'd0);
  endtask

  typedef struct {
    logic [23:0] pat;
    logic [15:0] j1;
    logic [15:0] j2;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    int len, falls, d0;
    logic prev, prevl;
    logic [23:0] rp, pa, pb;
    logic [15:0] keep1, keep2;

    vecs[0] = '{24'hFFDFFE, 16'h0001, 16'h0002};
    vecs[1] = '{24'h000000, 16'h0FFF, 16'h0FFF};
    vecs[2] = '{24'hFFF000, 16'h0FFF, 16'h0000};
    vecs[3] = '{24'h000FFF, 16'h0000, 16'h0FFF};
    vecs[4] = '{24'h5A5A5A, 16'h05A5, 16'h0A5A};
    vecs[5] = '{24'h123456, 16'h0BA9, 16'h0EDC};

    reset_n = 1'b0;
    pattern = '1;
    repeat (4) @(negedge clk_sys);
    #1;
    chk("reset JOY_CLK", 32'(joy_if.JOY_CLK), 32'd1);
    chk("reset JOY_LOAD", 32'(joy_if.JOY_LOAD), 32'd1);
    chk("reset joystick1", 32'(joy_if.joystick1), 32'd0);
    chk("reset joystick2", 32'(joy_if.joystick2), 32'd0);
    chk("reset frame_done", 32'(joy_if.frame_done), 32'd0);
    #1 reset_n = 1'b1;

    // First LOAD one prescaler period after release, low for two ticks
    wait_load("first LOAD", 1'b0);
    chk("first LOAD cycle", 32'(n), 32'd48);
    len = 0;
    while (joy_if.JOY_LOAD === 1'b0 && len < 1000) begin
      len++;
      @(negedge clk_sys);
    end
    chk("LOAD low length", 32'(len), 32'd96);

    wait_done("first frame");
    chk("first frame_done cycle", 32'(n), 32'd2448);
    chk("idle joystick1", 32'(joy_if.joystick1), 32'd0);
    chk("idle joystick2", 32'(joy_if.joystick2), 32'd0);

    foreach (vecs[i]) begin
      pattern = vecs[i].pat;
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d joystick1", i), 32'(joy_if.joystick1), 32'(vecs[i].j1));
      chk($sformatf("vec%0d joystick2", i), 32'(joy_if.joystick2), 32'(vecs[i].j2));
    end

    // Frame period and JOY_CLK falls between consecutive LOAD falling edges
    wait_load("period start", 1'b0);
    len = 0; falls = 0;
    prev = joy_if.JOY_CLK; prevl = joy_if.JOY_LOAD;
    do begin
      @(negedge clk_sys);
      len++;
      if (prev === 1'b1 && joy_if.JOY_CLK === 1'b0) falls++;
      if (joy_if.JOY_LOAD === 1'b0 && prevl === 1'b1) break;
      prev = joy_if.JOY_CLK;
      prevl = joy_if.JOY_LOAD;
    end while (len < 5000);
    chk("frame period", 32'(len), 32'(FRAME_CYC));
    chk("JOY_CLK falls per frame", 32'(falls), 32'd24);

    wait_done("pre-random");
    for (int r = 0; r < 3; r++) begin
      rp = 24'($urandom);
      pattern = rp;
      wait_done($sformatf("rand%0d", r));
      chk($sformatf("rand%0d joystick1", r), 32'(joy_if.joystick1), {20'h0, ~rp[11:0]});
      chk($sformatf("rand%0d joystick2", r), 32'(joy_if.joystick2), {20'h0, ~rp[23:12]});
    end

    // Alternating A,B,A,B: debounce must hold, plain build follows B
    pa = 24'hAAAAAA;
    pb = 24'h555555;
    #1;
    keep1 = joy_if.joystick1;
    keep2 = joy_if.joystick2;
    d0 = done_cnt;
    for (int a = 0; a < 4; a++) begin
      pattern = (a % 2 == 0) ? pa : pb;
      wait_load("alt load", 1'b0);
      wait_load("alt shift", 1'b1);
    end
    wait_load("alt end", 1'b0);
    #1;
    chk("alt frame_done count", 32'(done_cnt - d0), DEBOUNCE ? 32'd0 : 32'd4);
    chk("alt joystick1", 32'(joy_if.joystick1), DEBOUNCE ? 32'(keep1) : {20'h0, ~pb[11:0]});
    chk("alt joystick2", 32'(joy_if.joystick2), DEBOUNCE ? 32'(keep2) : {20'h0, ~pb[23:12]});

    // Abort at bit index 10 with an asynchronous reset
    falls = 0; len = 0;
    prev = joy_if.JOY_CLK;
    while (falls < 11 && len < WAIT_LIM) begin
      @(negedge clk_sys);
      len++;
      if (prev === 1'b1 && joy_if.JOY_CLK === 1'b0) falls++;
      prev = joy_if.JOY_CLK;
    end
    chk("timeout bit10", 32'(len >= WAIT_LIM), 32'd0);
    #3 reset_n = 1'b0;
    #1;
    chk("abort JOY_CLK", 32'(joy_if.JOY_CLK), 32'd1);
    chk("abort JOY_LOAD", 32'(joy_if.JOY_LOAD), 32'd1);
    chk("abort joystick1", 32'(joy_if.joystick1), 32'd0);
    chk("abort joystick2", 32'(joy_if.joystick2), 32'd0);
    chk("abort frame_done", 32'(joy_if.frame_done), 32'd0);
    pattern = '1;
    repeat (3) @(negedge clk_sys);
    #2 reset_n = 1'b1;
    wait_done("after abort");
    chk("frame_done after abort", 32'(n), 32'd2448);
    repeat (10) @(negedge clk_sys);
    #1;

    chk("timeline JOY_LOAD errors", 32'(err_load), 32'd0);
    chk("timeline JOY_CLK errors", 32'(err_clk), 32'd0);
    chk("timeline frame_done errors", 32'(err_done), 32'd0);
    chk("timeline joystick errors", 32'(err_joy), 32'd0);
    chk("invariant errors", 32'(err_inv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
